// File: rtl/cdc_fifo_pkg.sv
// Shared definitions for the dual-clock FIFO write and read controllers.
package cdc_fifo_pkg;

  // Controller life cycle: INIT covers reset propagation to the far domain.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_t;

  // Pointer width carries one extra wrap bit above the memory address.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Occupancy between two pointers; callers truncate the result to their
  // pointer width, which gives the modulo-2**(ADDR_WIDTH+1) wrap.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/cdc_fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO: accepts a valid/ready write
// stream, drives the memory write port, and derives full/almost-full/level
// from the read pointer synchronized back into this domain.
module cdc_fifo_wr_ctrl
  import cdc_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int AFULL_FREE  = 2,
  parameter int INIT_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]   wr_ptr_bin,
  input  logic [ADDR_WIDTH:0]   rd_ptr_sync,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  init_done,
  output logic                  ptr_err
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(INIT_CYCLES) + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  localparam ptr_t DEPTH_P  = ptr_t'(DEPTH);
  localparam ptr_t AFULL_TH = ptr_t'(DEPTH - AFULL_FREE);

  ctrl_state_t      state;
  logic [CNT_W-1:0] init_cnt;
  ptr_t             wr_ptr_next;
  ptr_t             diff;

  // Accept only in RUN with room and a consistent pointer pair; the memory
  // write happens on the accepting edge at the current pointer's address.
  assign wr_ready  = (state == ST_RUN) & ~full & ~ptr_err;
  assign mem_we    = wr_valid & wr_ready;
  assign mem_waddr = wr_ptr_bin[ADDR_WIDTH-1:0];
  assign mem_wdata = wr_data;

  // Flags look ahead to the post-accept pointer so the DEPTH-th accept
  // raises full on the same edge, with no overshoot.
  assign wr_ptr_next = wr_ptr_bin + ptr_t'(mem_we);
  assign diff        = PTR_W'(ptr_diff(32'(wr_ptr_next), 32'(rd_ptr_sync)));

  // INIT holds off writes for INIT_CYCLES edges after reset, then RUN forever.
  always_ff @(posedge clk or posedge reset_p) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset_p) begin
      state     <= ST_INIT;
      init_cnt  <= CNT_W'(INIT_CYCLES - 1);
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == '0) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt - CNT_W'(1);
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_INIT;
      endcase
    end
  end

  // Write pointer advances by at most one per edge, as the gray stage needs;
  // level and flags are registered from the look-ahead difference.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      wr_ptr_bin  <= '0;
      wr_level    <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      ptr_err     <= 1'b0;
    end else begin
      wr_ptr_bin  <= wr_ptr_next;
      wr_level    <= diff;
      full        <= (diff >= DEPTH_P);
      almost_full <= (diff >= AFULL_TH);
      // More than DEPTH apart cannot happen with sane pointers; latch it so
      // writes stay blocked until the whole FIFO is reset.
      if (diff > DEPTH_P) begin
        ptr_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cdc_fifo_wr_ctrl.sv
// Self-checking bench for cdc_fifo_wr_ctrl: directed stimulus pushes expected
// memory writes into a scoreboard queue; a monitor pops and compares them
// whenever the DUT asserts mem_we. Flag checks use hand-computed values.
module tb_cdc_fifo_wr_ctrl;

  localparam int ADDR_WIDTH  = 4;
  localparam int DATA_WIDTH  = 32;
  localparam int AFULL_FREE  = 2;
  localparam int INIT_CYCLES = 8;

  logic                  clk;
  logic                  reset_p;
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH:0]   wr_ptr_bin;
  logic [ADDR_WIDTH:0]   rd_ptr_sync;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  init_done;
  logic                  ptr_err;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } exp_wr_t;

  exp_wr_t exp_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;
  logic    wrapped;

  cdc_fifo_wr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AFULL_FREE (AFULL_FREE),
    .INIT_CYCLES(INIT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .wr_ptr_bin (wr_ptr_bin),
    .rd_ptr_sync(rd_ptr_sync),
    .full       (full),
    .almost_full(almost_full),
    .wr_level   (wr_level),
    .init_done  (init_done),
    .ptr_err    (ptr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every memory write the DUT presents must match the next
  // expected write, in order.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected none (t=%0t)",
                 mem_waddr, mem_wdata, $time);
      end else begin
        exp_wr_t e;
        e = exp_q.pop_front();
        check("mem_waddr", 32'(mem_waddr), 32'(e.addr));
        check("mem_wdata", mem_wdata, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One write attempt lasting one cycle; called at posedge+1.
  task automatic do_write(input logic [DATA_WIDTH-1:0] data, input logic exp_acc,
                          input logic [ADDR_WIDTH-1:0] exp_addr);
    wr_valid = 1'b1;
    wr_data  = data;
    if (exp_acc) exp_q.push_back('{addr: exp_addr, data: data});
    @(negedge clk);
    check("wr_ready", 32'(wr_ready), 32'(exp_acc));
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_ready"},    32'(wr_ready),    32'd0);
    check({tag, "_mem_we"},      32'(mem_we),      32'd0);
    check({tag, "_mem_waddr"},   32'(mem_waddr),   32'd0);
    check({tag, "_wr_ptr_bin"},  32'(wr_ptr_bin),  32'd0);
    check({tag, "_full"},        32'(full),        32'd0);
    check({tag, "_almost_full"}, 32'(almost_full), 32'd0);
    check({tag, "_wr_level"},    32'(wr_level),    32'd0);
    check({tag, "_init_done"},   32'(init_done),   32'd0);
    check({tag, "_ptr_err"},     32'(ptr_err),     32'd0);
  endtask

  // Reset, release, and walk through INIT; returns at posedge+1 in RUN
  // with wr_valid low and rd_ptr_sync at 0.
  task automatic init_seq(input logic hold_valid);
    reset_p     = 1'b1;
    wr_valid    = hold_valid;
    wr_data     = 32'hDEAD_BEEF;
    rd_ptr_sync = '0;
    #1;
    check_all_zero("reset");
    step();
    step();
    check_all_zero("reset_held");
    reset_p = 1'b0;
    for (int i = 0; i < INIT_CYCLES; i++) begin
      @(negedge clk);
      check("init_wr_ready", 32'(wr_ready), 32'd0);
      check("init_init_done", 32'(init_done), 32'd0);
      step();
    end
    check("run_wr_ready", 32'(wr_ready), 32'd1);
    check("run_init_done", 32'(init_done), 32'd1);
    wr_valid = 1'b0;
  endtask

  initial begin
    reset_p     = 1'b1;
    wr_valid    = 1'b0;
    wr_data     = '0;
    rd_ptr_sync = '0;
    wrapped     = 1'b0;

    // Reset and INIT with wr_valid held high.
    init_seq(1'b1);

    // Fill 16 entries with the read pointer at 0.
    for (int i = 0; i < 16; i++) begin
      do_write(32'hA000_0000 + 32'(i), 1'b1, 4'(i));
      if (i == 12) check("afull_after_13", 32'(almost_full), 32'd0);
      if (i == 13) check("afull_after_14", 32'(almost_full), 32'd1);
      if (i == 14) check("full_after_15", 32'(full), 32'd0);
    end
    check("full_after_16", 32'(full), 32'd1);
    check("ptr_after_16", 32'(wr_ptr_bin), 32'd16);
    check("level_after_16", 32'(wr_level), 32'd16);
    do_write(32'hA000_0010, 1'b0, 4'd0);
    wr_valid = 1'b0;

    // Read side frees 5 entries.
    rd_ptr_sync = 5'd5;
    step();
    check("full_after_rd5", 32'(full), 32'd0);
    check("level_after_rd5", 32'(wr_level), 32'd11);
    check("afull_after_rd5", 32'(almost_full), 32'd0);
    for (int i = 0; i < 5; i++) begin
      do_write(32'hB000_0000 + 32'(i), 1'b1, 4'(i));
      check("full_refill", 32'(full), (i == 4) ? 32'd1 : 32'd0);
    end
    check("ptr_after_refill", 32'(wr_ptr_bin), 32'd21);
    do_write(32'hB000_0005, 1'b0, 4'd0);
    wr_valid = 1'b0;

    // Wrap: steady stream with reads at matching rate, level stays 8.
    rd_ptr_sync = 5'd13;
    step();
    check("level_before_wrap", 32'(wr_level), 32'd8);
    for (int i = 0; i < 100; i++) begin
      rd_ptr_sync = rd_ptr_sync + 5'd1;
      do_write(32'hC000_0000 + 32'(i), 1'b1, 4'(5 + i));
      check("full_during_wrap", 32'(full), 32'd0);
      if (wr_ptr_bin == '0) wrapped = 1'b1;
    end
    wr_valid = 1'b0;
    check("ptr_after_wrap", 32'(wr_ptr_bin), 32'd25);
    check("level_after_wrap", 32'(wr_level), 32'd8);
    check("ptr_wrapped", 32'(wrapped), 32'd1);

    // Reset in the middle of a burst at wr_ptr_bin=7.
    init_seq(1'b0);
    for (int i = 0; i < 7; i++) do_write(32'hE000_0000 + 32'(i), 1'b1, 4'(i));
    check("ptr_before_midreset", 32'(wr_ptr_bin), 32'd7);
    wr_valid = 1'b1;
    wr_data  = 32'hE000_0007;
    #2;
    reset_p = 1'b1;
    #1;
    check_all_zero("async_reset");
    init_seq(1'b1);

    // Legal wrapped difference, then an inconsistent read pointer.
    rd_ptr_sync = 5'd20;
    step();
    check("level_rd20", 32'(wr_level), 32'd12);
    check("ptr_err_rd20", 32'(ptr_err), 32'd0);
    check("wr_ready_rd20", 32'(wr_ready), 32'd1);
    rd_ptr_sync = 5'd8;
    step();
    check("ptr_err_rd8", 32'(ptr_err), 32'd1);
    check("full_rd8", 32'(full), 32'd1);
    check("level_rd8", 32'(wr_level), 32'd24);
    rd_ptr_sync = 5'd0;
    step();
    check("ptr_err_sticky", 32'(ptr_err), 32'd1);
    check("full_cleared", 32'(full), 32'd0);
    do_write(32'hF000_0000, 1'b0, 4'd0);
    wr_valid = 1'b0;

    // Reset clears the error; first write lands at address 0.
    init_seq(1'b0);
    check("ptr_err_cleared", 32'(ptr_err), 32'd0);
    do_write(32'hD000_0000, 1'b1, 4'd0);
    wr_valid = 1'b0;
    check("ptr_after_first", 32'(wr_ptr_bin), 32'd1);

    step();
    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
